lsu_stage: RTL and testbench
============================

# lsu_stage

Parametrised memory-access pipeline stage for the RISC-V core, between execute and writeback. It performs byte/half/word loads with sign or zero extension and byte-enabled stores against a memory port with a request/grant/response handshake. It stalls the upstream pipeline for variable-latency memory, registers the instruction and ALU result for writeback, and exposes the load bypass value and destination register to execute.

## Interface
- ADDR_WIDTH, 12: byte-address width presented to data memory.
- XLEN, 32: data/address datapath width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_i  in  32  instruction from execute; 0 is a bubble
- alu_result_i  in  XLEN  effective address, or ALU result for non-memory ops
- rs2_data_i  in  XLEN  store data
- stall_o  out  1  upstream holds instr_i/alu_result_i/rs2_data_i stable while high
- instr_o, alu_result_o  out  32/XLEN  registered to writeback
- data_o  out  XLEN  registered, extended load data
- data_bypass_o  out  XLEN  extended load data in the DONE cycle, else 0
- sel_rd_o  out  5  rd of instr_o if it writes a register, else 0
- misaligned_o  out  1  one-cycle flag, see Configuration
- mem_req_o  out  1  request, held until granted
- mem_we_o  out  1  1 = store
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata_o  out  XLEN  store data replicated across lanes
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i, mem_rdata_i  in  1/XLEN  load response

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE: a load/store on instr_i goes to REQ (stall_o=1). Other instructions pass through; stall_o=0.
- REQ: mem_req_o/we/be/addr/wdata driven from state registers. On mem_gnt_i: store goes to DONE, load goes to RSP. stall_o=1.
- RSP: on mem_rvalid_i, capture mem_rdata_i and go to DONE. stall_o=1.
- DONE: stall_o=0. Pipeline registers and data_o load at the edge, then return to IDLE.
- mem_rvalid_i outside RSP is ignored.
- Pipeline registers load only when stall_o=0.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend. The lane is selected by addr[1:0] (byte) or addr[1] (half).
- Stores: SB sets be = 1<<addr[1:0], data replicated ×4. SH sets be = 4'b0011 or 4'b1100, data ×2. SW sets be = 4'b1111.
- sel_rd_o is nonzero for loads, R-type, I-ALU, LUI, AUIPC, JAL and JALR. It is 0 for stores, branches, bubbles and rd=x0.
- Reset: state goes to IDLE, and every output is 0 at the edge after rst, including mem_req_o. An in-flight transaction is abandoned. Its late response is dropped.

## Timing
- Non-memory op: one cycle, no stall.
- Store with grant in the first REQ cycle: 3 cycles (IDLE, REQ, DONE), 2 of them stalled.
- Load with grant in REQ and rvalid the next cycle: 4 cycles (IDLE, REQ, RSP, DONE), 3 stalled.
- Each extra cycle of grant or response wait adds one stall cycle.
- Back-to-back memory ops: DONE goes to IDLE and the next op starts in IDLE. There is no overlap and at most one outstanding request.
- data_bypass_o is valid combinationally in DONE. data_o is valid the cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A word with addr[1:0]≠0, or a half with addr[0]≠0, goes IDLE to DONE directly with no memory request.
  - In that DONE cycle misaligned_o=1, data_o and data_bypass_o are 0, and sel_rd_o for that instruction is 0.
- Undefined:
  - misaligned_o is tied 0.
  - Low address bits are ignored: a word uses the aligned word, a half uses addr[1] only.

## Test plan
- Reset with rst high for 2 cycles mid-REQ -> all outputs 0 and mem_req_o low after the first edge. An rvalid arriving afterwards is ignored.
- SW x2=0xDEADBEEF at 0x104, grant after 2 wait cycles -> mem_be_o=4'hF, mem_addr_o=0x104, mem_wdata_o=0xDEADBEEF, stall_o high for 4 cycles.
- LB at 0x203 with rdata=0x80FF1234 -> data_o=0xFFFFFF80 and sel_rd_o=rd. LBU at the same address gives 0x00000080.
- SH 0xABCD at 0x302 -> mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD. LH at 0x302 with the same rdata gives 0xFFFFABCD.
- ADD followed by LW with a zero-wait memory -> ADD completes in 1 cycle, LW stalls 3 cycles, data_bypass_o equals rdata only in DONE.
- With LSU_MISALIGN_TRAP_EN, LW at 0x101 -> no mem_req_o, misaligned_o pulses once, sel_rd_o=0. Without the macro -> mem_addr_o=0x100 and a normal load.

Source files
------------

// File: rtl/lsu_stage_if.sv
// Data-memory port of the LSU: request/grant handshake plus load response.
// Master is the LSU side, slave is the memory side.
interface lsu_stage_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int XLEN       = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [XLEN-1:0]       mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [XLEN-1:0]       mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_stage.sv
// RISC-V memory stage: byte/half/word loads (sign/zero extend) and byte-enabled stores; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: non-memory op 1 cycle; store 3 cycles, load 4 cycles, plus one per grant/response wait cycle.
// Backpressure: stall_o holds upstream while a memory op is in IDLE/REQ/RSP; memory grant and rvalid pace the FSM.
module lsu_stage #(
    parameter int ADDR_WIDTH = 12,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              stall_o,
    output logic [31:0]       instr_o,
    output logic [XLEN-1:0]   alu_result_o,
    output logic [XLEN-1:0]   data_o,
    output logic [XLEN-1:0]   data_bypass_o,
    output logic [4:0]        sel_rd_o,
    output logic              misaligned_o,
    lsu_stage_if.master       mem
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  stall;
    logic                  is_load_i, is_store_i, is_mem_i, mis_i;
    logic [2:0]            f3_i;
    logic [1:0]            lo_i;
    logic [3:0]            be_i;
    logic [XLEN-1:0]       wdata_i;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            lo_q;
    logic [3:0]            be_q;
    logic [XLEN-1:0]       wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       rdata_q;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_ext;
    logic                  trap_now;

    logic [31:0]           instr_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       data_q;
    logic                  trap_wb_q;
    logic                  writes_rd;

    assign f3_i       = instr_i[14:12];
    assign lo_i       = alu_result_i[1:0];
    assign is_load_i  = (instr_i[6:0] == OPC_LOAD);
    assign is_store_i = (instr_i[6:0] == OPC_STORE);
    assign is_mem_i   = is_load_i | is_store_i;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_i = is_mem_i && (((f3_i[1:0] == 2'b10) && (lo_i != 2'b00)) ||
                                ((f3_i[1:0] == 2'b01) && lo_i[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (state_q == IDLE) begin
            mis_q <= mis_i;
        end
    end

    assign trap_now = (state_q == DONE) && mis_q;
`else
    assign mis_i    = 1'b0;
    assign trap_now = 1'b0;
`endif

    // Store lanes: byte and half data are replicated so any enabled lane carries it
    always_comb begin
        be_i    = 4'b1111;
        wdata_i = rs2_data_i;
        case (f3_i[1:0])
            2'b00: begin
                be_i    = 4'b0001 << lo_i;
                wdata_i = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                be_i    = lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_i = {2{rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lo_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && is_mem_i) begin
                we_q    <= is_store_i;
                f3_q    <= f3_i;
                lo_q    <= lo_i;
                be_q    <= be_i;
                wdata_q <= wdata_i;
                addr_q  <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
            end
            if ((state_q == RSP) && mem.mem_rvalid_i) begin
                rdata_q <= mem.mem_rdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem_i) begin
                    stall   = 1'b1;
                    state_d = mis_i ? DONE : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem.mem_gnt_i) begin
                    state_d = we_q ? DONE : RSP;
                end
            end
            RSP: begin
                stall = 1'b1;
                if (mem.mem_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = rdata_q[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    assign data_bypass_o = ((state_q == DONE) && !we_q && !trap_now) ? ld_ext : '0;
    assign misaligned_o  = trap_now;
    assign stall_o       = stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            alu_q     <= '0;
            data_q    <= '0;
            trap_wb_q <= 1'b0;
        end else if (!stall) begin
            instr_q   <= instr_i;
            alu_q     <= alu_result_i;
            data_q    <= data_bypass_o;
            trap_wb_q <= trap_now;
        end
    end

    always_comb begin
        case (instr_q[6:0])
            OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    end

    assign instr_o      = instr_q;
    assign alu_result_o = alu_q;
    assign data_o       = data_q;
    assign sel_rd_o     = (writes_rd && !trap_wb_q) ? instr_q[11:7] : 5'd0;

    assign mem.mem_req_o   = (state_q == REQ);
    assign mem.mem_we_o    = (state_q == REQ) && we_q;
    assign mem.mem_be_o    = (state_q == REQ) ? be_q : 4'b0000;
    assign mem.mem_addr_o  = (state_q == REQ) ? addr_q : '0;
    assign mem.mem_wdata_o = (state_q == REQ) ? wdata_q : '0;
endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed cases then random ops against a behavioural model with a wait-state memory.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i, alu_i, rs2_i;
    logic        stall_o, misaligned_o;
    logic [31:0] instr_o, alu_result_o, data_o, data_bypass_o;
    logic [4:0]  sel_rd_o;

    always #5 clk = ~clk;

    lsu_stage_if #(.ADDR_WIDTH(12), .XLEN(32)) mif ();

    lsu_stage #(.ADDR_WIDTH(12), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .alu_result_i  (alu_i),
        .rs2_data_i    (rs2_i),
        .stall_o       (stall_o),
        .instr_o       (instr_o),
        .alu_result_o  (alu_result_o),
        .data_o        (data_o),
        .data_bypass_o (data_bypass_o),
        .sel_rd_o      (sel_rd_o),
        .misaligned_o  (misaligned_o),
        .mem           (mif)
    );

    int tests = 0;
    int fails = 0;

    int          o_stalls, o_reqc, o_mis, o_bad_byp;
    bit          o_timeout;
    logic [31:0] o_byp, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [4:0] rd);
        return {12'h000, 5'd1, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] mk_st(input logic [2:0] f3);
        return {7'h00, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] mk_add(input logic [4:0] rd);
        return {7'h00, 5'd3, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    // Reference load extension from the ISA rules, using plain arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // Drives one instruction and plays a memory with gw grant-wait and rw response-wait cycles
    task automatic run_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                          input int gw, input int rw, input logic [31:0] rdata);
        int reqc = 0;
        int rspc = 0;
        bit granted = 0;
        bit fin = 0;
        o_stalls = 0; o_reqc = 0; o_mis = 0; o_bad_byp = 0;
        o_byp = 'x; o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0;
        @(posedge clk); #1;
        instr_i = ins; alu_i = alu; rs2_i = rs2;
        mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0;
                if (granted) begin
                    if (rspc == rw) begin
                        mif.mem_rvalid_i = 1;
                        mif.mem_rdata_i  = rdata;
                    end
                    rspc++;
                end else if (mif.mem_req_o) begin
                    if (reqc == gw) begin
                        mif.mem_gnt_i = 1;
                        granted = 1;
                    end else begin
                        mif.mem_rvalid_i = 1;
                        mif.mem_rdata_i  = ~rdata;
                    end
                    reqc++;
                end
            end
            @(negedge clk);
            if (mif.mem_req_o) begin
                o_reqc++;
                o_be = mif.mem_be_o; o_addr = 32'(mif.mem_addr_o);
                o_wdata = mif.mem_wdata_o; o_we = mif.mem_we_o;
            end
            if (misaligned_o) o_mis++;
            if (stall_o) begin
                o_stalls++;
                if (data_bypass_o !== 32'h0) o_bad_byp++;
            end else begin
                o_byp = data_bypass_o;
                fin = 1;
            end
        end
        o_timeout = !fin;
        @(posedge clk); #1;
        instr_i = 0; alu_i = 0; rs2_i = 0;
        mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0;
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input logic [31:0] ins, input logic [31:0] alu,
                            input logic [31:0] rs2, input int gw, input int rw,
                            input logic [31:0] rdata);
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          ld, st, mis, wr;
        int          e_stalls;
        logic [31:0] e_data, e_wd;
        logic [3:0]  e_be;
        opc = ins[6:0];
        f3  = ins[14:12];
        ld  = (opc == 7'b0000011);
        st  = (opc == 7'b0100011);
        wr  = opc inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b0110111,
                          7'b0010111, 7'b1101111, 7'b1100111};
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (ld || st) && (((f3 % 4 == 2) && (alu % 4 != 0)) || ((f3 % 4 == 1) && (alu % 2 != 0)));
`else
        mis = 0;
`endif
        if (!(ld || st))  e_stalls = 0;
        else if (mis)     e_stalls = 1;
        else if (st)      e_stalls = gw + 2;
        else              e_stalls = gw + rw + 3;
        e_data = (ld && !mis) ? ref_load(f3, alu, rdata) : 32'h0;

        run_op(ins, alu, rs2, gw, rw, rdata);

        check({tag, ".timeout"}, 32'(o_timeout), 0);
        check({tag, ".stalls"}, o_stalls, e_stalls);
        check({tag, ".reqcyc"}, o_reqc, ((ld || st) && !mis) ? gw + 1 : 0);
        check({tag, ".bypass"}, o_byp, e_data);
        check({tag, ".byp_early"}, o_bad_byp, 0);
        check({tag, ".mispulse"}, o_mis, mis ? 1 : 0);
        check({tag, ".data_o"}, data_o, e_data);
        check({tag, ".instr_o"}, instr_o, ins);
        check({tag, ".alu_o"}, alu_result_o, alu);
        check({tag, ".sel_rd"}, 32'(sel_rd_o), (wr && !mis) ? 32'(ins[11:7]) : 0);
        if ((ld || st) && !mis) begin
            check({tag, ".addr"}, o_addr, (alu % 4096) - (alu % 4));
            check({tag, ".we"}, 32'(o_we), st ? 1 : 0);
        end
        if (st && !mis) begin
            case (f3 % 4)
                0: begin e_be = 4'(1 << (alu % 4)); e_wd = (rs2 % 256) * 32'h0101_0101; end
                1: begin e_be = ((alu / 2) % 2 == 1) ? 4'hC : 4'h3; e_wd = (rs2 % 65536) * 32'h0001_0001; end
                default: begin e_be = 4'hF; e_wd = rs2; end
            endcase
            check({tag, ".be"}, 32'(o_be), 32'(e_be));
            check({tag, ".wdata"}, o_wdata, e_wd);
        end
    endtask

    initial begin
        logic [31:0] ins, alu, rs2, rdata;
        logic [2:0]  f3;
        int          kind;

        rst = 1; instr_i = 0; alu_i = 0; rs2_i = 0;
        mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0; mif.mem_rdata_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.stall", 32'(stall_o), 0);
        check("rst.instr_o", instr_o, 0);
        check("rst.data_o", data_o, 0);
        check("rst.bypass", data_bypass_o, 0);
        check("rst.sel_rd", 32'(sel_rd_o), 0);
        check("rst.req", 32'(mif.mem_req_o), 0);
        check("rst.mis", 32'(misaligned_o), 0);

        // Reset arriving while a load sits in REQ with no grant
        @(posedge clk); #1;
        rst = 0; instr_i = mk_ld(3'd2, 5'd7); alu_i = 32'h40;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq.req_before", 32'(mif.mem_req_o), 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq.req", 32'(mif.mem_req_o), 0);
        check("rstreq.stall", 32'(stall_o), 0);
        check("rstreq.instr_o", instr_o, 0);
        check("rstreq.sel_rd", 32'(sel_rd_o), 0);
        @(posedge clk); #1;
        rst = 0; instr_i = 0; alu_i = 0;
        mif.mem_rvalid_i = 1; mif.mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late.stall", 32'(stall_o), 0);
        check("late.req", 32'(mif.mem_req_o), 0);
        check("late.bypass", data_bypass_o, 0);
        @(posedge clk); #1;
        mif.mem_rvalid_i = 0;
        @(negedge clk);
        check("late.data_o", data_o, 0);
        check("late.req2", 32'(mif.mem_req_o), 0);

        check_op("sw", mk_st(3'd2), 32'h104, 32'hDEAD_BEEF, 2, 0, 32'h0);
        check_op("lb", mk_ld(3'd0, 5'd5), 32'h203, 32'h0, 0, 0, 32'h80FF_1234);
        check_op("lbu", mk_ld(3'd4, 5'd6), 32'h203, 32'h0, 0, 0, 32'h80FF_1234);
        check_op("sh", mk_st(3'd1), 32'h302, 32'h0000_ABCD, 0, 0, 32'h0);
        check_op("lh", mk_ld(3'd1, 5'd9), 32'h302, 32'h0, 1, 2, 32'hABCD_1234);
        check_op("add", mk_add(5'd11), 32'h1234_5678, 32'h0, 0, 0, 32'h0);
        check_op("lw", mk_ld(3'd2, 5'd12), 32'h208, 32'h0, 0, 0, 32'hCAFE_F00D);
        check_op("lw_mis", mk_ld(3'd2, 5'd13), 32'h101, 32'h0, 0, 0, 32'h1357_9BDF);
        check_op("sb0", mk_st(3'd0), 32'h3F1, 32'h1234_56A5, 1, 0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 3);
            alu   = $urandom;
            rs2   = $urandom;
            rdata = $urandom;
            case (kind)
                0: begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 == 3'd3) f3 = 3'd5;
                    ins = mk_ld(f3, 5'($urandom));
                end
                1: ins = mk_st(3'($urandom_range(0, 2)));
                2: ins = mk_add(5'($urandom));
                default: ins = ($urandom_range(0, 1) == 1) ? {20'($urandom), 5'($urandom), 7'b0110111}
                                                          : {20'($urandom), 5'($urandom), 7'b1100011};
            endcase
            check_op($sformatf("rnd%0d", n), ins, alu, rs2,
                     $urandom_range(0, 3), $urandom_range(0, 3), rdata);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
